datapath_sequencer: RTL and testbench

- Hardwired control unit that drives the SPARC datapath's load enables, mux selects and memory strobes for a defined instruction subset.
- Sequences fetch, decode, execute and PC advance.
- Waits on the memory's MOC handshake with a bounded timeout.
- Vectors to the trap base on a register-window trap.
- Sits beside the datapath: consumes IR, MOC, Cond and Trap; produces every control input the subset needs.

---
 rtl/datapath_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Purpose : hardwired control unit sequencing fetch/decode/execute/PC-advance for a SPARC datapath subset.
// Latency : one state per clock; outputs are registered from the next state (wait-state load enables also gated by MOC).
// Backpressure: stalls in FETCH1/LD_MEM/ST_MEM until MOC; halts after MOC_TIMEOUT cycles without it.
// Ports   : Clock/Reset (sync, active-low); IR, MOC, Cond, Trap in; register loads, mux selects,
//           ALU OP, memory strobes (MOV/RW/SU/SIZE), Halt and debug State out.
module datapath_sequencer #(
    parameter logic [5:0] OP_ADD      = 6'b000000,
    parameter logic [5:0] OP_PASSA    = 6'b111110,
    parameter logic [5:0] OP_PASSB    = 6'b111111,
    parameter int         MOC_TIMEOUT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        MOC,
    input  logic        Cond,
    input  logic        Trap,
    output logic        RF_Ld,
    output logic        FR_Ld,
    output logic        IR_Ld,
    output logic        MAR_Ld,
    output logic        MDR_Ld,
    output logic        nPC_Ld,
    output logic        PC_Ld,
    output logic [1:0]  MUX_A,
    output logic [1:0]  MUX_B,
    output logic [1:0]  MUX_OP,
    output logic [1:0]  MUX_RFA,
    output logic [1:0]  MUX_nPC,
    output logic [1:0]  MUX_PC,
    output logic [1:0]  MUX_Add4,
    output logic [1:0]  MUX_MDR,
    output logic [5:0]  OP,
    output logic        MOV,
    output logic        RW,
    output logic        SU,
    output logic [1:0]  SIZE,
    output logic        Halt,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,  S_FETCH0  = 4'd1,  S_FETCH1   = 4'd2,  S_DECODE  = 4'd3,
        S_EXEC_ALU = 4'd4,  S_LD_ADDR = 4'd5,  S_LD_MEM   = 4'd6,  S_LD_WB   = 4'd7,
        S_ST_ADDR  = 4'd8,  S_ST_DATA = 4'd9,  S_ST_MEM   = 4'd10, S_BRANCH  = 4'd11,
        S_BR_TAKEN = 4'd12, S_ADVANCE = 4'd13, S_TRAP     = 4'd14, S_HALT    = 4'd15
    } state_t;

    typedef struct packed {
        logic       rf_ld, fr_ld, ir_ld, mar_ld, mdr_ld, npc_ld, pc_ld;
        logic       moc_gate;   // loads in this state only fire on the MOC cycle
        logic [1:0] mux_a, mux_b, mux_op, mux_rfa, mux_npc, mux_pc, mux_add4, mux_mdr;
        logic [5:0] op;
        logic       mov, rw, halt;
    } ctl_t;

    localparam int             CW       = $clog2(MOC_TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MOC_TIMEOUT - 1);

    state_t        state, nxt;
    ctl_t          ctl;
    logic [CW-1:0] cnt;
    logic          timed_out, is_wait, is_win, gate_ok;
    logic          unused_ir;

    function automatic ctl_t decode(input state_t s, input logic ir13, input logic ir23);
        ctl_t c;
        c    = '0;
        c.rw = 1'b1;
        case (s)
            S_RESET, S_TRAP: begin  // PC <- TBR, nPC <- TBR + 4
                c.pc_ld = 1'b1; c.mux_pc = 2'd2; c.npc_ld = 1'b1; c.mux_npc = 2'd0; c.mux_add4 = 2'd1;
            end
            S_FETCH0: begin
                c.mux_a = 2'd1; c.mux_op = 2'd1; c.op = OP_PASSA; c.mar_ld = 1'b1;
            end
            S_FETCH1: begin
                c.mov = 1'b1; c.ir_ld = 1'b1; c.moc_gate = 1'b1;
            end
            S_EXEC_ALU: begin
                c.mux_b = {1'b0, ir13}; c.rf_ld = 1'b1; c.fr_ld = ir23;
            end
            S_LD_ADDR, S_ST_ADDR: begin
                c.mux_b = {1'b0, ir13}; c.mux_op = 2'd1; c.op = OP_ADD; c.mar_ld = 1'b1;
            end
            S_LD_MEM: begin
                c.mov = 1'b1; c.mdr_ld = 1'b1; c.moc_gate = 1'b1;
            end
            S_LD_WB: begin
                c.mux_b = 2'd2; c.mux_op = 2'd1; c.op = OP_PASSB; c.rf_ld = 1'b1;
            end
            S_ST_DATA: begin  // rd through port A into MDR
                c.mux_rfa = 2'd1; c.mux_op = 2'd1; c.op = OP_PASSA; c.mux_mdr = 2'd1; c.mdr_ld = 1'b1;
            end
            S_ST_MEM: begin
                c.mov = 1'b1; c.rw = 1'b0;
            end
            S_BR_TAKEN: begin  // PC <- old nPC and nPC <- PC + disp on the same edge
                c.pc_ld = 1'b1; c.mux_a = 2'd1; c.mux_b = 2'd1; c.mux_op = 2'd1;
                c.op = OP_ADD; c.mux_npc = 2'd2; c.npc_ld = 1'b1;
            end
            S_ADVANCE: begin
                c.pc_ld = 1'b1; c.npc_ld = 1'b1;
            end
            S_HALT: c.halt = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign timed_out = (cnt == CNT_LAST);
    assign is_wait   = (state == S_FETCH1) || (state == S_LD_MEM) || (state == S_ST_MEM);
    assign is_win    = (IR[24:20] == 5'b11110);  // SAVE (111100) / RESTORE (111101)
    assign unused_ir = ^{IR[29:25], IR[18:14], IR[12:0]};

    always_comb begin
        nxt = state;
        case (state)
            S_RESET:    nxt = S_FETCH0;
            S_FETCH0:   nxt = S_FETCH1;
            S_FETCH1:   if (MOC) nxt = S_DECODE;  else if (timed_out) nxt = S_HALT;
            S_DECODE: begin
                if (IR[31:30] == 2'b10)
                    nxt = (is_win && Trap) ? S_TRAP : S_EXEC_ALU;
                else if (IR[31:30] == 2'b11)
                    nxt = IR[21] ? S_ST_ADDR : S_LD_ADDR;
                else if (IR[31:30] == 2'b00 && IR[24:22] == 3'b010)
                    nxt = S_BRANCH;
                else
                    nxt = S_ADVANCE;
            end
            S_EXEC_ALU: nxt = S_ADVANCE;
            S_LD_ADDR:  nxt = S_LD_MEM;
            S_LD_MEM:   if (MOC) nxt = S_LD_WB;   else if (timed_out) nxt = S_HALT;
            S_LD_WB:    nxt = S_ADVANCE;
            S_ST_ADDR:  nxt = S_ST_DATA;
            S_ST_DATA:  nxt = S_ST_MEM;
            S_ST_MEM:   if (MOC) nxt = S_ADVANCE; else if (timed_out) nxt = S_HALT;
            S_BRANCH:   nxt = Cond ? S_BR_TAKEN : S_ADVANCE;
            S_BR_TAKEN, S_ADVANCE, S_TRAP: nxt = S_FETCH0;
            S_HALT:     nxt = S_HALT;
            default:    nxt = S_RESET;
        endcase
    end

    // Outputs are decoded from the state being entered so they line up with State.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= S_RESET;
            cnt   <= '0;
            ctl   <= decode(S_RESET, IR[13], IR[23]);
        end else begin
            state <= nxt;
            ctl   <= decode(nxt, IR[13], IR[23]);
            if (nxt != state)
                cnt <= '0;  // leaving any state clears, so every wait starts at 0
            else if (is_wait && !MOC)
                cnt <= cnt + CW'(1);
        end
    end

    assign gate_ok  = MOC | ~ctl.moc_gate;
    assign RF_Ld    = ctl.rf_ld  & gate_ok;
    assign FR_Ld    = ctl.fr_ld  & gate_ok;
    assign IR_Ld    = ctl.ir_ld  & gate_ok;
    assign MAR_Ld   = ctl.mar_ld & gate_ok;
    assign MDR_Ld   = ctl.mdr_ld & gate_ok;
    assign nPC_Ld   = ctl.npc_ld & gate_ok;
    assign PC_Ld    = ctl.pc_ld  & gate_ok;
    assign MUX_A    = ctl.mux_a;
    assign MUX_B    = ctl.mux_b;
    assign MUX_OP   = ctl.mux_op;
    assign MUX_RFA  = ctl.mux_rfa;
    assign MUX_nPC  = ctl.mux_npc;
    assign MUX_PC   = ctl.mux_pc;
    assign MUX_Add4 = ctl.mux_add4;
    assign MUX_MDR  = ctl.mux_mdr;
    assign OP       = ctl.op;
    assign MOV      = ctl.mov;
    assign RW       = ctl.rw;
    assign SU       = 1'b1;
    assign SIZE     = 2'b10;
    assign Halt     = ctl.halt;
    assign State    = state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Purpose : directed stimulus for datapath_sequencer with a cycle-tagged expectation queue.
// Latency : each expectation is tagged with the cycle it describes and checked on that cycle's falling edge.
// Backpressure: MOC is driven per cycle to exercise waits, the last-cycle MOC win and the timeout halt.
module tb_datapath_sequencer;

    localparam int X = -1;
    localparam logic [8:0] E_RF = 9'b1_0000_0000, E_FR = 9'b0_1000_0000, E_IR = 9'b0_0100_0000,
                           E_MAR = 9'b0_0010_0000, E_MDR = 9'b0_0001_0000, E_NPC = 9'b0_0000_1000,
                           E_PC = 9'b0_0000_0100, E_MOV = 9'b0_0000_0010, E_HALT = 9'b0_0000_0001;

    logic        Clock = 1'b0;
    logic        Reset, MOC, Cond, Trap;
    logic [31:0] IR;
    logic        RF_Ld, FR_Ld, IR_Ld, MAR_Ld, MDR_Ld, nPC_Ld, PC_Ld;
    logic [1:0]  MUX_A, MUX_B, MUX_OP, MUX_RFA, MUX_nPC, MUX_PC, MUX_Add4, MUX_MDR, SIZE;
    logic [5:0]  OP;
    logic        MOV, RW, SU, Halt;
    logic [3:0]  State;

    datapath_sequencer #(.MOC_TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MOC(MOC), .Cond(Cond), .Trap(Trap),
        .RF_Ld(RF_Ld), .FR_Ld(FR_Ld), .IR_Ld(IR_Ld), .MAR_Ld(MAR_Ld), .MDR_Ld(MDR_Ld),
        .nPC_Ld(nPC_Ld), .PC_Ld(PC_Ld), .MUX_A(MUX_A), .MUX_B(MUX_B), .MUX_OP(MUX_OP),
        .MUX_RFA(MUX_RFA), .MUX_nPC(MUX_nPC), .MUX_PC(MUX_PC), .MUX_Add4(MUX_Add4),
        .MUX_MDR(MUX_MDR), .OP(OP), .MOV(MOV), .RW(RW), .SU(SU), .SIZE(SIZE),
        .Halt(Halt), .State(State)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [8:0] en;
        logic [23:0] dmask;
        logic [23:0] dval;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Datapath-control fields to check; -1 means "not checked".
    // Layout: MUX_A,MUX_B,MUX_OP,MUX_RFA,MUX_nPC,MUX_PC,MUX_Add4,MUX_MDR (2b each), OP (6b), RW, SU.
    function automatic logic [47:0] dp(input int a, b, op, rfa, npc, pc, add4, mdr, opc, rw);
        int vals[10];
        int los[10];
        int ws[10];
        logic [23:0] m, v;
        vals = '{a, b, op, rfa, npc, pc, add4, mdr, opc, rw};
        los  = '{22, 20, 18, 16, 14, 12, 10, 8, 2, 1};
        ws   = '{2, 2, 2, 2, 2, 2, 2, 2, 6, 1};
        m = 24'h000001;  // SU is always checked
        v = 24'h000001;
        for (int i = 0; i < 10; i++)
            if (vals[i] >= 0)
                for (int k = 0; k < ws[i]; k++) begin
                    m[los[i] + k] = 1'b1;
                    v[los[i] + k] = vals[i][k];
                end
        return {m, v};
    endfunction

    task automatic nxt();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input logic [3:0] st, input logic [8:0] en, input logic [47:0] d);
        exp_t e;
        e.cyc = cyc; e.st = st; e.en = en; e.dmask = d[47:24]; e.dval = d[23:0];
        q.push_back(e);
    endtask

    // Monitor: compares every expectation tagged for the current cycle.
    always @(negedge Clock) begin
        logic [8:0]  en_a;
        logic [23:0] dp_a;
        exp_t e;
        en_a = {RF_Ld, FR_Ld, IR_Ld, MAR_Ld, MDR_Ld, nPC_Ld, PC_Ld, MOV, Halt};
        dp_a = {MUX_A, MUX_B, MUX_OP, MUX_RFA, MUX_nPC, MUX_PC, MUX_Add4, MUX_MDR, OP, RW, SU};
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.cyc != cyc) begin
                bad++; $display("FAIL missed cyc=%0d expected-at=%0d", cyc, e.cyc);
            end
            total++;
            if (State !== e.st) begin
                bad++; $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, State, e.st);
            end
            total++;
            if (en_a !== e.en) begin
                bad++; $display("FAIL enables cyc=%0d st=%0d got=%b want=%b", cyc, e.st, en_a, e.en);
            end
            total++;
            if ((dp_a & e.dmask) !== e.dval || SIZE !== 2'b10) begin
                bad++; $display("FAIL dpctl cyc=%0d st=%0d got=%h want=%h mask=%h size=%b",
                                cyc, e.st, dp_a, e.dval, e.dmask, SIZE);
            end
        end
    end

    // Per-state expectations, hand-written from the state table.
    task automatic x_reset();     chk(0,  E_PC | E_NPC, dp(X, X, X, X, 0, 2, 1, X, X, 1));  endtask
    task automatic x_trap();      chk(14, E_PC | E_NPC, dp(X, X, X, X, 0, 2, 1, X, X, 1));  endtask
    task automatic x_f0();        chk(1,  E_MAR, dp(1, X, 1, X, X, X, X, X, 62, 1));        endtask
    task automatic x_f1(input logic m); chk(2, m ? (E_IR | E_MOV) : E_MOV, dp(X, X, X, X, X, X, X, X, X, 1)); endtask
    task automatic x_dec();       chk(3,  9'd0, dp(X, X, X, X, X, X, X, X, X, 1));          endtask
    task automatic x_alu(input int b, input logic fr); chk(4, E_RF | (fr ? E_FR : 9'd0), dp(0, b, 0, X, X, X, X, X, X, 1)); endtask
    task automatic x_addr(input logic [3:0] st, input int b); chk(st, E_MAR, dp(0, b, 1, X, X, X, X, X, 0, 1)); endtask
    task automatic x_ldm(input logic m); chk(6, E_MOV | (m ? E_MDR : 9'd0), dp(X, X, X, X, X, X, X, 0, X, 1)); endtask
    task automatic x_ldwb();      chk(7,  E_RF, dp(X, 2, 1, X, X, X, X, X, 63, 1));         endtask
    task automatic x_std();       chk(9,  E_MDR, dp(0, X, 1, 1, X, X, X, 1, 62, 1));        endtask
    task automatic x_stm();       chk(10, E_MOV, dp(X, X, X, X, X, X, X, X, X, 0));         endtask
    task automatic x_br();        chk(11, 9'd0, dp(X, X, X, X, X, X, X, X, X, 1));          endtask
    task automatic x_brt();       chk(12, E_PC | E_NPC, dp(1, 1, 1, X, 2, 0, X, X, 0, 1));  endtask
    task automatic x_adv();       chk(13, E_PC | E_NPC, dp(X, X, X, X, 0, 0, 0, X, X, 1));  endtask
    task automatic x_halt();      chk(15, E_HALT, dp(X, X, X, X, X, X, X, X, X, 1));        endtask

    // FETCH0, FETCH1 (n cycles without MOC, then MOC), DECODE.
    task automatic fetch_dec(input int n);
        nxt(); MOC = 1'b1; x_f0();
        for (int i = 0; i < n; i++) begin nxt(); MOC = 1'b0; x_f1(1'b0); end
        nxt(); MOC = 1'b1; x_f1(1'b1);
        nxt(); x_dec();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d queue=%0d", cyc, q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; MOC = 1'b1; Cond = 1'b0; Trap = 1'b0; IR = 32'h82006005;
        repeat (3) begin nxt(); x_reset(); end
        Reset = 1'b1;

        // add %g1,5,%g1: imm operand, no flags
        fetch_dec(0); nxt(); x_alu(1, 1'b0); nxt(); x_adv();
        // addcc %g1,%g1,%g1: register operand, flags loaded
        IR = 32'h82804001;
        fetch_dec(0); nxt(); x_alu(0, 1'b1); nxt(); x_adv();
        // ld [%g1+4],%g2 with MOC three cycles late
        IR = 32'hC4006004;
        fetch_dec(0); nxt(); x_addr(5, 1);
        repeat (3) begin nxt(); MOC = 1'b0; x_ldm(1'b0); end
        nxt(); MOC = 1'b1; x_ldm(1'b1);
        nxt(); x_ldwb(); nxt(); x_adv();
        // st %g2,[%g1+4] with one-cycle late fetch and store
        IR = 32'hC4206004;
        fetch_dec(1); nxt(); x_addr(8, 1); nxt(); x_std();
        nxt(); MOC = 1'b0; x_stm();
        nxt(); MOC = 1'b1; x_stm();
        nxt(); x_adv();
        // ba +4, taken then not taken
        IR = 32'h10800004; Cond = 1'b1;
        fetch_dec(0); nxt(); x_br(); nxt(); x_brt();
        Cond = 1'b0;
        fetch_dec(0); nxt(); x_br(); nxt(); x_adv();
        // SAVE / RESTORE with a window trap, then SAVE without one
        IR = 32'h81E00000; Trap = 1'b1;
        fetch_dec(0); nxt(); x_trap();
        IR = 32'h81E80000;
        fetch_dec(0); nxt(); x_trap();
        IR = 32'h81E00000; Trap = 1'b0;
        fetch_dec(0); nxt(); x_alu(0, 1'b1); nxt(); x_adv();
        // sethi decodes as NOP; MOC arrives on the last allowed wait cycle
        IR = 32'h03000000;
        fetch_dec(15); nxt(); x_adv();
        // MOC never arrives: 16 cycles in FETCH1, then HALT until reset
        nxt(); MOC = 1'b1; x_f0();
        repeat (16) begin nxt(); MOC = 1'b0; x_f1(1'b0); end
        nxt(); x_halt();
        nxt(); x_halt(); Reset = 1'b0;
        nxt(); x_reset(); Reset = 1'b1; MOC = 1'b1;
        nxt(); x_f0();

        repeat (2) nxt();
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
